// File: rtl/ov7670_frame_gen.sv
// OV7670-style DVP transmitter: VSYNC/HREF/8-bit RGB565 stream with a
// deterministic {x, y, frame} test pattern, one byte per clk.
module ov7670_frame_gen #(
    parameter int H_PIXELS  = 160,
    parameter int V_LINES   = 120,
    parameter int VSYNC_LEN = 3,
    parameter int V_BACK    = 17,
    parameter int H_BLANK   = 16,
    parameter int V_FRONT   = 10
) (
    input  logic       clk,
    input  logic       in_reset,
    input  logic       enable,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int LINE_BYTES = 2 * H_PIXELS;
    localparam int M1   = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int M2   = (M1 > LINE_BYTES) ? M1 : LINE_BYTES;
    localparam int M3   = (M2 > H_BLANK) ? M2 : H_BLANK;
    localparam int CMAX = (M3 > V_FRONT) ? M3 : V_FRONT;
    localparam int CW   = $clog2(CMAX);
    localparam int YW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    localparam logic [CW-1:0] VS_LAST = CW'(VSYNC_LEN - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(V_BACK - 1);
    localparam logic [CW-1:0] LN_LAST = CW'(LINE_BYTES - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] VF_LAST = CW'(V_FRONT - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_LINES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_LINE,
        ST_HBLANK,
        ST_VFRONT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [YW-1:0] y, y_n;
    logic          end_frame;
    logic [CW-1:0] xi;
    logic [15:0]   pixel;
    logic [7:0]    byte_n;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        y_n       = y;
        end_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n = ST_VSYNC;
                    cnt_n   = '0;
                end
            end
            ST_VSYNC: begin
                if (cnt == VS_LAST) begin
                    state_n = ST_VBACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_VBACK: begin
                if (cnt == VB_LAST) begin
                    state_n = ST_LINE;
                    cnt_n   = '0;
                    y_n     = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LINE: begin
                if (cnt == LN_LAST) begin
                    state_n = ST_HBLANK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt == HB_LAST) begin
                    cnt_n = '0;
                    if (y == Y_LAST) begin
                        state_n = ST_VFRONT;
                    end else begin
                        state_n = ST_LINE;
                        y_n     = y + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_VFRONT: begin
                if (cnt == VF_LAST) begin
                    end_frame = 1'b1;
                    cnt_n     = '0;
                    state_n   = enable ? ST_VSYNC : ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                y_n     = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        xi     = cnt_n >> 1;
        pixel  = {5'(xi), 6'(y_n), frame_cnt[4:0]};
        byte_n = cnt_n[0] ? pixel[7:0] : pixel[15:8];
    end

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            y          <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            y          <= y_n;
            vsync      <= (state_n == ST_VSYNC);
            href       <= (state_n == ST_LINE);
            data       <= (state_n == ST_LINE) ? byte_n : '0;
            frame_done <= (state_n == ST_VFRONT) && (cnt_n == VF_LAST);
            if (end_frame) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_gen.sv
// Bench for ov7670_frame_gen: per-cycle comparison against a frame-timeline
// model plus scenario-specific checks on timing and pixel bytes.
module tb_ov7670_frame_gen;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HB = 2;
    localparam int VF = 2;
    localparam int L  = 2 * H + HB;
    localparam int FL = VS + VB + V * L + VF;

    logic       clk = 1'b0;
    logic       in_reset = 1'b1;
    logic       enable = 1'b0;
    logic       vsync, href, frame_done;
    logic [7:0] data, frame_cnt;
    logic [18:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_active = 1'b0;
    int m_t = 0;
    int m_fc = 0;

    always #5 clk = ~clk;

    ov7670_frame_gen #(
        .H_PIXELS(H), .V_LINES(V), .VSYNC_LEN(VS),
        .V_BACK(VB), .H_BLANK(HB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .in_reset(in_reset), .enable(enable),
        .vsync(vsync), .href(href), .data(data),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    assign dut_vec = {vsync, href, data, frame_done, frame_cnt};

    // Expected outputs from the position m_t within the frame timeline.
    function automatic logic [18:0] model_out();
        logic       vs, hr, dn;
        logic [7:0] d;
        int lt, ln, p, px;
        vs = 1'b0; hr = 1'b0; dn = 1'b0; d = 8'h00;
        if (m_active) begin
            if (m_t < VS) vs = 1'b1;
            else if (m_t >= VS + VB && m_t < VS + VB + V * L) begin
                lt = m_t - VS - VB;
                ln = lt / L;
                p  = lt % L;
                if (p < 2 * H) begin
                    hr = 1'b1;
                    px = (((p / 2) & 31) << 11) | ((ln & 63) << 5) | (m_fc & 31);
                    d  = (p % 2 == 0) ? px[15:8] : px[7:0];
                end
            end
            if (m_t == FL - 1) dn = 1'b1;
        end
        return {vs, hr, d, dn, m_fc[7:0]};
    endfunction

    task automatic tick();
        logic en_s, rs_s;
        en_s = enable;
        rs_s = in_reset;
        @(posedge clk);
        if (rs_s) begin
            m_active = 1'b0; m_t = 0; m_fc = 0;
        end else if (!m_active) begin
            if (en_s) begin m_active = 1'b1; m_t = 0; end
        end else if (m_t == FL - 1) begin
            m_fc = (m_fc + 1) % 256;
            if (en_s) m_t = 0;
            else begin m_active = 1'b0; m_t = 0; end
        end else begin
            m_t++;
        end
        #1;
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        enable = 1'b0;
        tick();
        in_reset = 1'b0;
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (dut_vec !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_state got %h want %h", dut_vec, 19'h0);
        end
        in_reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL idle_k%0d got %h want %h", k, dut_vec, model_out());
            end
        end
    endtask

    task automatic test_single_frame();
        int vs_n = 0, hr_n = 0, first_hr = -1, done_at = -1, dn_n = 0, both = 0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        n_cmp++;
        if (vsync !== 1'b1) begin
            n_bad++;
            $display("FAIL vsync_latency got %b want 1", vsync);
        end
        for (int k = 0; k < FL + 8; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL single_k%0d got %h want %h", k, dut_vec, model_out());
            end
            if (vsync === 1'b1) vs_n++;
            if (href === 1'b1) begin
                hr_n++;
                if (first_hr < 0) first_hr = k;
            end
            if (vsync === 1'b1 && href === 1'b1) both++;
            if (frame_done === 1'b1) begin
                dn_n++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
        n_cmp++;
        if (vs_n != VS) begin n_bad++; $display("FAIL vsync_len got %0d want %0d", vs_n, VS); end
        n_cmp++;
        if (hr_n != V * 2 * H) begin n_bad++; $display("FAIL href_total got %0d want %0d", hr_n, V * 2 * H); end
        n_cmp++;
        if (first_hr != VS + VB) begin n_bad++; $display("FAIL first_href got %0d want %0d", first_hr, VS + VB); end
        n_cmp++;
        if (done_at != FL - 1) begin n_bad++; $display("FAIL done_at got %0d want %0d", done_at, FL - 1); end
        n_cmp++;
        if (dn_n != 1) begin n_bad++; $display("FAIL done_count got %0d want 1", dn_n); end
        n_cmp++;
        if (both != 0) begin n_bad++; $display("FAIL vsync_href_overlap got %0d want 0", both); end
        n_cmp++;
        if (frame_cnt !== 8'd1 || vsync !== 1'b0) begin
            n_bad++;
            $display("FAIL after_frame got cnt=%0d vs=%b want cnt=1 vs=0", frame_cnt, vsync);
        end
    endtask

    task automatic test_data();
        logic [7:0] q[$];
        logic [7:0] exp0 [8];
        exp0 = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h18, 8'h00};
        do_reset();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < FL + 5; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL data_k%0d got %h want %h", k, dut_vec, model_out());
            end
            if (href === 1'b1) q.push_back(data);
            tick();
        end
        n_cmp++;
        if (q.size() != 24) begin
            n_bad++;
            $display("FAIL byte_count got %0d want 24", q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (q[i] !== exp0[i]) begin
                    n_bad++;
                    $display("FAIL line0_b%0d got %h want %h", i, q[i], exp0[i]);
                end
            end
            n_cmp++;
            if ({q[8], q[9]} !== 16'h0020) begin
                n_bad++;
                $display("FAIL line1_px0 got %h%h want 0020", q[8], q[9]);
            end
            n_cmp++;
            if ({q[22], q[23]} !== 16'h1840) begin
                n_bad++;
                $display("FAIL line2_px3 got %h%h want 1840", q[22], q[23]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0, want_fc = 1;
        bit prev_dn = 1'b0;
        logic [7:0] f1[$];
        do_reset();
        enable = 1'b1;
        tick();
        for (int k = 0; k < 3 * FL + 1; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL b2b_k%0d got %h want %h", k, dut_vec, model_out());
            end
            if (prev_dn) begin
                n_cmp++;
                if (vsync !== 1'b1 || frame_cnt !== 8'(want_fc)) begin
                    n_bad++;
                    $display("FAIL b2b_restart got vs=%b cnt=%0d want vs=1 cnt=%0d", vsync, frame_cnt, want_fc);
                end
                want_fc++;
            end
            if (dones == 1 && href === 1'b1) f1.push_back(data);
            prev_dn = (frame_done === 1'b1);
            if (prev_dn) dones++;
            tick();
        end
        enable = 1'b0;
        n_cmp++;
        if (dones != 3 || want_fc != 4) begin
            n_bad++;
            $display("FAIL b2b_frames got %0d/%0d want 3/4", dones, want_fc);
        end
        n_cmp++;
        if (f1.size() < 2) begin
            n_bad++;
            $display("FAIL f1_bytes got %0d want >=2", f1.size());
        end else if ({f1[0], f1[1]} !== 16'h0001) begin
            n_bad++;
            $display("FAIL f1_px00 got %h%h want 0001", f1[0], f1[1]);
        end
    endtask

    task automatic test_enable_drop();
        int done_at = -1, dn_n = 0, vs_after = 0;
        do_reset();
        enable = 1'b1;
        tick();
        for (int k = 0; k < FL + 8; k++) begin
            if (k == VS + VB + L + 2) enable = 1'b0;
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL drop_k%0d got %h want %h", k, dut_vec, model_out());
            end
            if (done_at >= 0 && vsync === 1'b1) vs_after++;
            if (frame_done === 1'b1) begin
                dn_n++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
        n_cmp++;
        if (done_at != FL - 1 || dn_n != 1) begin
            n_bad++;
            $display("FAIL drop_done got at=%0d n=%0d want at=%0d n=1", done_at, dn_n, FL - 1);
        end
        n_cmp++;
        if (vs_after != 0 || frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL drop_idle got vs=%0d cnt=%0d want vs=0 cnt=1", vs_after, frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int done_at = -1, dn_n = 0;
        do_reset();
        enable = 1'b1;
        tick();
        for (int k = 0; k < FL + VS + VB + 2 * L + 2; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL pre_rst_k%0d got %h want %h", k, dut_vec, model_out());
            end
            tick();
        end
        in_reset = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec !== 19'h0) begin
            n_bad++;
            $display("FAIL reset_mid got %h want %h", dut_vec, 19'h0);
        end
        in_reset = 1'b0;
        tick();
        for (int k = 0; k < FL + 5; k++) begin
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL post_rst_k%0d got %h want %h", k, dut_vec, model_out());
            end
            if (frame_done === 1'b1) begin
                dn_n++;
                if (done_at < 0) done_at = k;
            end
            tick();
        end
        n_cmp++;
        if (done_at != FL - 1 || dn_n != 1) begin
            n_bad++;
            $display("FAIL fresh_frame got at=%0d n=%0d want at=%0d n=1", done_at, dn_n, FL - 1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            enable   = ($urandom_range(0, 2) != 0);
            in_reset = ($urandom_range(0, 149) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== model_out()) begin
                n_bad++;
                $display("FAIL random_k%0d got %h want %h", k, dut_vec, model_out());
            end
        end
        in_reset = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_data();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
